// File: rtl/freq_topk_tracker.sv
// freq_topk_tracker: histograms LENGTH-sample frames, then scans one bin per cycle
// to publish the NUM_TOP most frequent values. Define FTK_FRAME_WRITE_EN for the frame-RAM echo port.

// One result slot of the shadow top-K list. A bin that beats this slot takes its
// place unless a slot above already took it, in which case the slot above shifts down here.
module ftk_slot #(
  parameter int DW = 4,
  parameter int CW = 7
) (
  input  logic [CW-1:0] bin_cnt,
  input  logic [DW-1:0] bin_val,
  input  logic [CW-1:0] own_cnt,
  input  logic [DW-1:0] own_val,
  input  logic [CW-1:0] up_cnt,
  input  logic [DW-1:0] up_val,
  input  logic          up_gt,
  output logic [CW-1:0] new_cnt,
  output logic [DW-1:0] new_val
);
  always_comb begin
    new_cnt = own_cnt;
    new_val = own_val;
    if (up_gt) begin
      new_cnt = up_cnt;
      new_val = up_val;
    end else if (bin_cnt > own_cnt) begin
      new_cnt = bin_cnt;
      new_val = bin_val;
    end
  end
endmodule

module freq_topk_tracker #(
  parameter int DATA_SIZE   = 4,
  parameter int DATA_NUM    = 16,
  parameter int LENGTH      = 64,
  parameter int LENGTH_SIZE = 6,
  parameter int NUM_TOP     = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 Collect,
  input  logic                                 Valid,
  input  logic [DATA_SIZE-1:0]                 Data,
  output logic                                 Ready,
  output logic                                 Overrun,
  output logic                                 SortValid,
  output logic [NUM_TOP*DATA_SIZE-1:0]         MaxData,
  output logic [NUM_TOP*(LENGTH_SIZE+1)-1:0]   MaxCount,
  output logic                                 FramEn,
  output logic [LENGTH_SIZE-1:0]               FramAdd,
  output logic [DATA_SIZE-1:0]                 FramData
);
  localparam int COUNT_W = LENGTH_SIZE + 1;

  typedef enum logic {COLLECT, SCAN} state_t;

  state_t                                  state_q, state_d;
  logic [DATA_NUM-1:0][COUNT_W-1:0]        hist_q, hist_d;
  logic [LENGTH_SIZE-1:0]                  idx_q, idx_d;
  logic [DATA_SIZE-1:0]                    scan_q, scan_d;
  logic [NUM_TOP-1:0][COUNT_W-1:0]         sh_cnt_q, sh_cnt_d;
  logic [NUM_TOP-1:0][DATA_SIZE-1:0]       sh_val_q, sh_val_d;
  logic [NUM_TOP-1:0][COUNT_W-1:0]         max_cnt_q, max_cnt_d;
  logic [NUM_TOP-1:0][DATA_SIZE-1:0]       max_val_q, max_val_d;
  logic                                    overrun_q, overrun_d;
  logic                                    sort_valid_q, sort_valid_d;
  logic [NUM_TOP-1:0][COUNT_W-1:0]         ins_cnt;
  logic [NUM_TOP-1:0][DATA_SIZE-1:0]       ins_val;
  logic [COUNT_W-1:0]                      bin_cnt;
  logic                                    accept;

  assign bin_cnt = hist_q[scan_q];
  assign accept  = Valid & Ready;

  // Insertion network: shadow list stays sorted non-increasing, so the
  // "strictly greater" flags are monotonic down the slots.
  for (genvar k = 0; k < NUM_TOP; k++) begin : g_slot
    logic [COUNT_W-1:0]   up_cnt;
    logic [DATA_SIZE-1:0] up_val;
    logic                 up_gt;
    if (k == 0) begin : g_head
      assign up_cnt = '0;
      assign up_val = '0;
      assign up_gt  = 1'b0;
    end else begin : g_tail
      assign up_cnt = sh_cnt_q[k-1];
      assign up_val = sh_val_q[k-1];
      assign up_gt  = bin_cnt > sh_cnt_q[k-1];
    end
    ftk_slot #(.DW(DATA_SIZE), .CW(COUNT_W)) u_slot (
      .bin_cnt (bin_cnt),
      .bin_val (scan_q),
      .own_cnt (sh_cnt_q[k]),
      .own_val (sh_val_q[k]),
      .up_cnt  (up_cnt),
      .up_val  (up_val),
      .up_gt   (up_gt),
      .new_cnt (ins_cnt[k]),
      .new_val (ins_val[k])
    );
  end

  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    idx_d        = idx_q;
    scan_d       = scan_q;
    sh_cnt_d     = sh_cnt_q;
    sh_val_d     = sh_val_q;
    max_cnt_d    = max_cnt_q;
    max_val_d    = max_val_q;
    sort_valid_d = 1'b0;
    Ready        = (state_q == COLLECT) & Collect & ~rst;
    overrun_d    = overrun_q | (Valid & Collect & ~Ready);
    case (state_q)
      COLLECT: begin
        if (accept) begin
          hist_d[Data] = hist_q[Data] + COUNT_W'(1);
          if (idx_q == LENGTH_SIZE'(LENGTH - 1)) begin
            state_d = SCAN;
            scan_d  = '0;
          end else begin
            idx_d = idx_q + LENGTH_SIZE'(1);
          end
        end
      end
      SCAN: begin
        hist_d[scan_q] = '0;
        sh_cnt_d       = ins_cnt;
        sh_val_d       = ins_val;
        scan_d         = scan_q + DATA_SIZE'(1);
        if (scan_q == DATA_SIZE'(DATA_NUM - 1)) begin
          max_cnt_d    = ins_cnt;
          max_val_d    = ins_val;
          sort_valid_d = 1'b1;
          sh_cnt_d     = '0;
          sh_val_d     = '0;
          idx_d        = '0;
          scan_d       = '0;
          state_d      = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= COLLECT;
      hist_q       <= '0;
      idx_q        <= '0;
      scan_q       <= '0;
      sh_cnt_q     <= '0;
      sh_val_q     <= '0;
      max_cnt_q    <= '0;
      max_val_q    <= '0;
      overrun_q    <= 1'b0;
      sort_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      idx_q        <= idx_d;
      scan_q       <= scan_d;
      sh_cnt_q     <= sh_cnt_d;
      sh_val_q     <= sh_val_d;
      max_cnt_q    <= max_cnt_d;
      max_val_q    <= max_val_d;
      overrun_q    <= overrun_d;
      sort_valid_q <= sort_valid_d;
    end
  end

  assign Overrun   = overrun_q;
  assign SortValid = sort_valid_q;
  assign MaxData   = max_val_q;
  assign MaxCount  = max_cnt_q;

`ifdef FTK_FRAME_WRITE_EN
  logic                   fram_en_q, fram_en_d;
  logic [LENGTH_SIZE-1:0] fram_add_q, fram_add_d;
  logic [DATA_SIZE-1:0]   fram_data_q, fram_data_d;

  // Address/data hold between strobes; only FramEn marks a write.
  always_comb begin
    fram_en_d   = accept;
    fram_add_d  = accept ? idx_q : fram_add_q;
    fram_data_d = accept ? Data  : fram_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fram_en_q   <= 1'b0;
      fram_add_q  <= '0;
      fram_data_q <= '0;
    end else begin
      fram_en_q   <= fram_en_d;
      fram_add_q  <= fram_add_d;
      fram_data_q <= fram_data_d;
    end
  end

  assign FramEn   = fram_en_q;
  assign FramAdd  = fram_add_q;
  assign FramData = fram_data_q;
`else
  assign FramEn   = 1'b0;
  assign FramAdd  = '0;
  assign FramData = '0;
`endif
endmodule

// File: tb/tb_freq_topk_tracker.sv
// Bench for freq_topk_tracker: directed frames from the test plan plus random traffic,
// all checked every cycle against a frame-level histogram/selection model.
module tb_freq_topk_tracker;
  localparam int DS = 4, DN = 16, LEN = 64, LS = 6, NT = 3, CW = LS + 1;

  logic clk = 1'b0, rst = 1'b1, Collect = 1'b0, Valid = 1'b0;
  logic [DS-1:0]    Data = '0;
  logic             Ready, Overrun, SortValid, FramEn;
  logic [NT*DS-1:0] MaxData;
  logic [NT*CW-1:0] MaxCount;
  logic [LS-1:0]    FramAdd;
  logic [DS-1:0]    FramData;

  int n_cmp = 0, n_bad = 0;

  freq_topk_tracker #(.DATA_SIZE(DS), .DATA_NUM(DN), .LENGTH(LEN),
                      .LENGTH_SIZE(LS), .NUM_TOP(NT)) dut (
    .clk(clk), .rst(rst), .Collect(Collect), .Valid(Valid), .Data(Data),
    .Ready(Ready), .Overrun(Overrun), .SortValid(SortValid),
    .MaxData(MaxData), .MaxCount(MaxCount),
    .FramEn(FramEn), .FramAdd(FramAdd), .FramData(FramData));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_hist[DN];
  int m_n, m_busy, m_fadd, m_fdat;
  bit m_ovr, m_sv, m_fen;
  int m_md[NT], m_mc[NT];

  task automatic model_reset();
    foreach (m_hist[v]) m_hist[v] = 0;
    m_n = 0; m_busy = 0; m_fadd = 0; m_fdat = 0;
    m_ovr = 0; m_sv = 0; m_fen = 0;
    foreach (m_md[k]) begin m_md[k] = 0; m_mc[k] = 0; end
  endtask

  // Selection of the NT largest bins; equal counts go to the lower value.
  task automatic model_publish();
    bit used[DN];
    int best, bc;
    foreach (used[v]) used[v] = 0;
    for (int k = 0; k < NT; k++) begin
      best = -1; bc = 0;
      for (int v = 0; v < DN; v++)
        if (!used[v] && m_hist[v] > bc) begin best = v; bc = m_hist[v]; end
      if (best >= 0) begin used[best] = 1; m_md[k] = best; m_mc[k] = bc; end
      else begin m_md[k] = 0; m_mc[k] = 0; end
    end
    foreach (m_hist[v]) m_hist[v] = 0;
    m_n = 0; m_sv = 1;
  endtask

  task automatic model_step(input bit rdy);
    m_sv = 0; m_fen = 0;
    if (Valid && Collect && !rdy) m_ovr = 1;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) model_publish();
    end else if (Valid && rdy) begin
      m_hist[Data]++;
      m_fen = 1; m_fadd = m_n; m_fdat = int'(Data);
      m_n++;
      if (m_n == LEN) m_busy = DN;
    end
  endtask

  // ---------------- compare process ----------------
  logic [NT*DS-1:0] emd;
  logic [NT*CW-1:0] emc;
  bit               erdy;

  initial forever begin
    @(negedge clk);
    if (rst) model_reset();
    erdy = !rst && m_busy == 0 && Collect;
    emd = '0; emc = '0;
    for (int k = 0; k < NT; k++) begin
      emd[k*DS +: DS] = DS'(m_md[k]);
      emc[k*CW +: CW] = CW'(m_mc[k]);
    end
    chk("Ready",     64'(Ready),     64'(erdy));
    chk("Overrun",   64'(Overrun),   64'(m_ovr));
    chk("SortValid", 64'(SortValid), 64'(m_sv));
    chk("MaxData",   64'(MaxData),   64'(emd));
    chk("MaxCount",  64'(MaxCount),  64'(emc));
`ifdef FTK_FRAME_WRITE_EN
    chk("FramEn",   64'(FramEn),   64'(m_fen));
    chk("FramAdd",  64'(FramAdd),  64'(m_fadd));
    chk("FramData", 64'(FramData), 64'(m_fdat));
`else
    chk("FramEn",   64'(FramEn),   64'(0));
    chk("FramAdd",  64'(FramAdd),  64'(0));
    chk("FramData", 64'(FramData), 64'(0));
`endif
    if (!rst) model_step(erdy);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit c, input bit v, input int d);
    @(posedge clk); #1;
    Collect = c; Valid = v; Data = DS'(d);
  endtask

  task automatic frame_const(input int d, input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, d);
  endtask

  // Idle until SortValid; lat = edges after the last accepted sample.
  task automatic wait_sv(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0);
      if (SortValid) begin lat = i; break; end
    end
    if (lat < 0) chk("sv_timeout", 64'(SortValid), 64'(1));
  endtask

  int lat, sum, nsv;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_MaxData", 64'(MaxData), 64'(0));

    // 64 x 5
    frame_const(5, LEN);
    wait_sv(lat);
    chk("t1_latency", 64'(lat), 64'(16));
    chk("t1_data",  64'(MaxData),  64'(12'h005));
    chk("t1_count", 64'(MaxCount), 64'({7'd0, 7'd0, 7'd64}));

    // 32x3, 16x9, 16x2: tie between 2 and 9 resolved toward 2
    frame_const(3, 32); frame_const(9, 16); frame_const(2, 16);
    wait_sv(lat);
    chk("t2_data",  64'(MaxData),  64'({4'd9, 4'd2, 4'd3}));
    chk("t2_count", 64'(MaxCount), 64'({7'd16, 7'd16, 7'd32}));

    // Collect paused mid-frame with Valid held
    for (int i = 0; i < 20; i++) cyc(1, 1, 1 + $urandom_range(0, 1));
    for (int i = 0; i < 10; i++) cyc(0, 1, 1);
    for (int i = 0; i < 44; i++) cyc(1, 1, 1 + $urandom_range(0, 1));
    wait_sv(lat);
    sum = int'(MaxCount[0 +: CW]) + int'(MaxCount[CW +: CW]) + int'(MaxCount[2*CW +: CW]);
    chk("t3_sum", 64'(sum), 64'(64));
    chk("t3_no_overrun", 64'(Overrun), 64'(0));

    // Valid during SCAN -> sticky Overrun, sample dropped
    frame_const(1, LEN);
    for (int i = 0; i < 3; i++) cyc(1, 1, 11);
    wait_sv(lat);
    chk("t4_overrun", 64'(Overrun), 64'(1));
    frame_const(6, LEN);
    wait_sv(lat);
    chk("t4_data",  64'(MaxData),  64'(12'h006));
    chk("t4_count", 64'(MaxCount), 64'({7'd0, 7'd0, 7'd64}));
    chk("t4_overrun_sticky", 64'(Overrun), 64'(1));

    // rst mid-SCAN
    frame_const(3, LEN);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t5_data_cleared",  64'(MaxData),  64'(0));
    chk("t5_count_cleared", 64'(MaxCount), 64'(0));
    chk("t5_overrun_cleared", 64'(Overrun), 64'(0));
    nsv = 0;
    for (int i = 0; i < 25; i++) begin cyc(0, 0, 0); if (SortValid) nsv++; end
    chk("t5_no_sv", 64'(nsv), 64'(0));
    frame_const(7, LEN);
    wait_sv(lat);
    chk("t5_data",  64'(MaxData),  64'(12'h007));
    chk("t5_count", 64'(MaxCount), 64'({7'd0, 7'd0, 7'd64}));

    // Ramp 0..15 x4: every bin 4, lowest values win
    for (int i = 0; i < LEN; i++) cyc(1, 1, i % 16);
    wait_sv(lat);
    chk("t6_data",  64'(MaxData),  64'({4'd2, 4'd1, 4'd0}));
    chk("t6_count", 64'(MaxCount), 64'({7'd4, 7'd4, 7'd4}));

    // Random traffic with occasional reset
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      rst     = ($urandom_range(0, 599) == 0);
      Collect = ($urandom_range(0, 7) != 0);
      Valid   = ($urandom_range(0, 3) != 0);
      Data    = $urandom_range(0, 1) ? DS'($urandom_range(0, 3)) : DS'($urandom_range(0, 15));
    end
    @(posedge clk); #1 rst = 1'b0; Collect = 1'b0; Valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/freq_topk_tracker.md
# freq_topk_tracker

Parametrised successor to the fixed three-entry frequency sorter. It accepts a stream of DATA_SIZE-bit samples and builds a histogram over frames of LENGTH accepted samples. At the end of each frame it scans all DATA_NUM bins and publishes the NUM_TOP most frequent values with their counts. It sits between the sample source (Valid/Data) and downstream consumers of the MaxData/MaxCount results, in a single clock domain.

## Interface
Parameters:
- DATA_SIZE, 4, sample width.
- DATA_NUM, 16, histogram bins; must equal 2**DATA_SIZE.
- LENGTH, 64, accepted samples per frame; 1 ≤ LENGTH ≤ 2**LENGTH_SIZE.
- LENGTH_SIZE, 6, sample-index width.
- NUM_TOP, 3, number of result slots; 1 ≤ NUM_TOP ≤ DATA_NUM.
- Derived localparam COUNT_W = LENGTH_SIZE+1, so a count of LENGTH never wraps.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- Collect  in  1  enables sample acceptance.
- Valid  in  1  sample strobe.
- Data  in  DATA_SIZE  sample value.
- Ready  out  1  high when a sample is accepted this cycle if Valid=1.
- Overrun  out  1  sticky; set when Valid=1 and Collect=1 while Ready=0.
- SortValid  out  1  one-cycle pulse; MaxData/MaxCount were updated this cycle.
- MaxData  out  NUM_TOP*DATA_SIZE  slot k at bits [k*DATA_SIZE +: DATA_SIZE]; slot 0 is the most frequent.
- MaxCount  out  NUM_TOP*COUNT_W  slot k count, same packing.
- FramEn  out  1  frame-write strobe (see Configuration).
- FramAdd  out  LENGTH_SIZE  frame-write address.
- FramData  out  DATA_SIZE  frame-write data.

## Operation
- States: COLLECT, SCAN.
- Reset values:
  - state=COLLECT; histogram, sample index and scan index all 0.
  - Ready=0 during reset.
  - Overrun, SortValid, MaxData, MaxCount, FramEn, FramAdd and FramData all 0.
- COLLECT:
  - Ready = Collect.
  - Acceptance: Valid & Ready; the accepted sample increments bin[Data] and the sample index.
  - When the LENGTH-th sample is accepted, go to SCAN with scan index 0.
  - Collect=0 only pauses acceptance; the partial frame is retained.
- SCAN:
  - Ready=0. One bin per cycle, in ascending index order.
  - Each bin is compared against a shadow top-K list and inserted with a shift-down.
  - A bin displaces a slot only if its count is strictly greater, so on ties the lower bin value ranks higher.
  - Bins with count 0 are never inserted; unfilled slots report data 0, count 0.
  - Each bin is cleared to 0 as it is read.
  - After bin DATA_NUM-1:
    - copy the shadow list to MaxData/MaxCount;
    - pulse SortValid;
    - clear the shadow list and sample index;
    - return to COLLECT.
- Overrun: cleared only by rst.
- Collect changes during SCAN have no effect on the scan.

## Timing
- Last frame sample accepted at edge T.
- SCAN occupies cycles T+1 … T+DATA_NUM.
- SortValid=1 and the new results are visible in cycle T+DATA_NUM+1.
- Ready returns to Collect in that same cycle, so a new frame can start there.
- Results hold until the next SortValid.
- Throughput: one sample per cycle in COLLECT.
- Frame period: at least LENGTH+DATA_NUM cycles.
- rst mid-SCAN or mid-frame: the scan is aborted and the histogram is zeroed. No SortValid is issued, and outputs return to their reset values.

## Configuration
- Macro FTK_FRAME_WRITE_EN.
- Defined: each accepted sample is echoed, registered one cycle later, as FramEn=1, FramAdd=sample index within frame (0…LENGTH-1), FramData=sample. This drives an external frame RAM.
- Undefined: FramEn, FramAdd and FramData are tied to 0 and no related logic is generated.

## Test plan
- 64 samples of value 5, Collect=1 -> SortValid at T+17; slot0=5/64, slots 1–2 = 0/0.
- 32×3, 16×9, 16×2 -> slots (3,32),(2,16),(9,16); the tie is ordered by lower value.
- Collect toggled 0 for 10 cycles mid-frame with Valid held -> Ready=0 for those cycles, no Overrun, and final counts sum to 64.
- Valid asserted during SCAN -> Overrun=1 and sticky; the sample is not counted in the next frame.
- rst pulsed mid-SCAN -> no SortValid and outputs 0. A following all-7 frame gives slot0=7/64, proving the histogram was cleared.
- FTK_FRAME_WRITE_EN defined, ramp 0..15 repeated -> FramEn each following cycle, FramAdd 0…63, FramData = sample. Undefined -> Fram* constant 0.
